// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types and defaults for the writeback arbiter.
//                wb_req_t bundles one writeback payload (active-list index,
//                result data, destination physical register, rd-write flag).
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

  localparam int WB_NUM_REQ   = 4;   // ALU0, ALU1, MEM, CSR
  localparam int WB_NUM_PORTS = 2;   // register-file / active-list write ports
  localparam int AL_SIZE      = 64;
  localparam int AL_IDX_W     = $clog2(AL_SIZE);
  localparam int PREG_W       = 6;

  typedef struct packed {
    logic [AL_IDX_W-1:0] al_idx;
    logic [31:0]         data;
    logic [PREG_W-1:0]   rd;
    logic                uses_rd;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_if
//  Description : Requester-side and writeback-side signal bundle.
//                slave  : arbiter view (takes req_*, flush; drives ready, wb_*)
//                master : requester/consumer view (the reverse)
//  Ports       : flush, req_valid/al_idx/data/rd/uses_rd, req_ready,
//                wb_valid/al_idx/data/rd/uses_rd
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_arbiter_if
  import riscv_pkg::*;
#(
  parameter int NUM_REQ   = WB_NUM_REQ,
  parameter int NUM_PORTS = WB_NUM_PORTS
) ();

  logic                                flush;
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0][AL_IDX_W-1:0]    req_al_idx;
  logic [NUM_REQ-1:0][31:0]            req_data;
  logic [NUM_REQ-1:0][PREG_W-1:0]      req_rd;
  logic [NUM_REQ-1:0]                  req_uses_rd;
  logic [NUM_REQ-1:0]                  req_ready;

  logic [NUM_PORTS-1:0]                wb_valid;
  logic [NUM_PORTS-1:0][AL_IDX_W-1:0]  wb_al_idx;
  logic [NUM_PORTS-1:0][31:0]          wb_data;
  logic [NUM_PORTS-1:0][PREG_W-1:0]    wb_rd;
  logic [NUM_PORTS-1:0]                wb_uses_rd;

  modport slave (
    input  flush, req_valid, req_al_idx, req_data, req_rd, req_uses_rd,
    output req_ready, wb_valid, wb_al_idx, wb_data, wb_rd, wb_uses_rd
  );

  modport master (
    output flush, req_valid, req_al_idx, req_data, req_rd, req_uses_rd,
    input  req_ready, wb_valid, wb_al_idx, wb_data, wb_rd, wb_uses_rd
  );

endinterface
`default_nettype wire

// File: rtl/wb_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : wb_rr_picker
//  Description : Combinational round-robin multi-grant selector. Entries are
//                ranked by their distance from rr_ptr (in scan order); the
//                valid entry of rank k is granted onto port k.
//  Ports       : valid    - candidate vector
//                rr_ptr   - first index to scan
//                grant    - per-port one-hot grant
//                next_ptr - (last granted index + 1) mod NUM_REQ, or rr_ptr
//                           when nothing is granted
//  Revision    : 1.0  initial release
// ============================================================================
module wb_rr_picker
  import riscv_pkg::*;
#(
  parameter int NUM_REQ   = WB_NUM_REQ,
  parameter int NUM_PORTS = WB_NUM_PORTS,
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]                valid,
  input  logic [PTR_W-1:0]                  rr_ptr,
  output logic [NUM_PORTS-1:0][NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]                  next_ptr
);

  int w_dist [NUM_REQ];   // scan position of each index relative to rr_ptr
  int w_rank [NUM_REQ];   // number of valid entries scanned before this one
  int w_last_dist;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist[i] = i - int'(rr_ptr);
      if (w_dist[i] < 0) w_dist[i] = w_dist[i] + NUM_REQ;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_rank[i] = 0;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (valid[j] && (w_dist[j] < w_dist[i])) w_rank[i] = w_rank[i] + 1;
      end
    end
  end

  // Distinct ranks guarantee a requester never lands on two ports.
  always_comb begin
    grant = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (valid[i] && (w_rank[i] == k)) grant[k][i] = 1'b1;
      end
    end
  end

  // The last granted entry is the granted one furthest along the scan.
  always_comb begin
    next_ptr    = rr_ptr;
    w_last_dist = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (valid[i] && (w_rank[i] < NUM_PORTS) && (w_dist[i] > w_last_dist)) begin
        w_last_dist = w_dist[i];
        next_ptr    = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Writeback arbiter. Each requester owns a one-entry hold
//                register; up to NUM_PORTS held entries are granted per
//                cycle in round-robin order and registered onto the wb ports.
//                Uncontended latency is two cycles from transfer to wb_*.
//                NUM_PORTS must lie in 1..NUM_REQ.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset (beats flush)
//                bus  - wb_arbiter_if.slave (flush, req_*, req_ready, wb_*)
//  Revision    : 1.0  initial release
// ============================================================================
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int NUM_REQ   = WB_NUM_REQ,
  parameter int NUM_PORTS = WB_NUM_PORTS,
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  wb_arbiter_if.slave      bus
);

  logic    [NUM_REQ-1:0]                r_hold_valid;
  wb_req_t [NUM_REQ-1:0]                r_hold;
  logic    [PTR_W-1:0]                  r_rr_ptr;
  logic    [NUM_PORTS-1:0]              r_wb_valid;
  wb_req_t [NUM_PORTS-1:0]              r_wb;

  logic    [NUM_PORTS-1:0][NUM_REQ-1:0] w_grant;
  logic    [NUM_REQ-1:0]                w_any_grant;
  logic    [PTR_W-1:0]                  w_next_ptr;
  logic    [NUM_REQ-1:0]                w_xfer;
  wb_req_t [NUM_REQ-1:0]                w_req_in;
  wb_req_t [NUM_PORTS-1:0]              w_port_pl;
  logic    [NUM_PORTS-1:0]              w_port_vld;

  wb_rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .valid    (r_hold_valid),
    .rr_ptr   (r_rr_ptr),
    .grant    (w_grant),
    .next_ptr (w_next_ptr)
  );

  always_comb begin
    w_any_grant = '0;
    for (int k = 0; k < NUM_PORTS; k++) w_any_grant = w_any_grant | w_grant[k];
  end

  // Ready depends only on registered state, so a granted hold can accept a
  // new payload on the same edge it drains.
  assign bus.req_ready = ~r_hold_valid | w_any_grant;
  assign w_xfer        = bus.req_valid & bus.req_ready & {NUM_REQ{~bus.flush}};

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_in[i].al_idx  = bus.req_al_idx[i];
      w_req_in[i].data    = bus.req_data[i];
      w_req_in[i].rd      = bus.req_rd[i];
      w_req_in[i].uses_rd = bus.req_uses_rd[i];
    end
  end

  // One-hot grant makes an AND-OR mux sufficient.
  always_comb begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_port_vld[k] = |w_grant[k];
      w_port_pl[k]  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        w_port_pl[k] = w_port_pl[k] | (r_hold[i] & {$bits(wb_req_t){w_grant[k][i]}});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= '0;
      r_hold       <= '0;
    end else if (bus.flush) begin
      r_hold_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_xfer[i]) begin
          r_hold_valid[i] <= 1'b1;
          r_hold[i]       <= w_req_in[i];
        end else if (w_any_grant[i]) begin
          r_hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // The pointer follows grants even in a flush cycle; flush only squashes data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (|w_any_grant) begin
      r_rr_ptr <= w_next_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid <= '0;
      r_wb       <= '0;
    end else begin
      r_wb_valid <= bus.flush ? '0 : w_port_vld;
      r_wb       <= w_port_pl;
    end
  end

  assign bus.wb_valid = r_wb_valid;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    assign bus.wb_al_idx[k]  = r_wb[k].al_idx;
    assign bus.wb_data[k]    = r_wb[k].data;
    assign bus.wb_rd[k]      = r_wb[k].rd;
    assign bus.wb_uses_rd[k] = r_wb[k].uses_rd;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of writeback requesters (ALU0, ALU1, MEM, CSR).
REQ-002 Parameter NUM_PORTS, default 2: number of register-file/active-list writeback ports; SHALL be 1..NUM_REQ.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  pipeline squash (branch mispredict/exception); drops all in-flight writebacks.
REQ-007 req_valid  input  NUM_REQ  requester i presents a writeback.
REQ-008 req_al_idx  input  NUM_REQ x $clog2(AL_SIZE)  active-list index per requester.
REQ-009 req_data  input  NUM_REQ x 32  result data per requester.
REQ-010 req_rd  input  NUM_REQ x 6  physical destination register per requester.
REQ-011 req_uses_rd  input  NUM_REQ  requester writes rd.
REQ-012 req_ready  output  NUM_REQ  requester i may transfer this cycle.
REQ-013 wb_valid, wb_al_idx, wb_data, wb_rd, wb_uses_rd  output  NUM_PORTS x (1, $clog2(AL_SIZE), 32, 6, 1)  per-port writeback, same meaning as the wb_ifc fields.

Function
REQ-014 Each requester SHALL own a 1-entry hold register (hold_valid[i] plus payload); a transfer occurs when req_valid[i] && req_ready[i] && !flush.
REQ-015 req_ready[i] SHALL equal !hold_valid[i] || grant[i], computed from registered state only, with no combinational path from any req_* input.
REQ-016 Each cycle the arbiter SHALL issue up to NUM_PORTS grants among entries with hold_valid set, scanning indices rr_ptr, rr_ptr+1, ... mod NUM_REQ; the k-th granted entry drives port k.
REQ-017 Granted entries SHALL be registered onto wb_* on the next edge; ports without a grant SHALL drive wb_valid=0, and their payload is don't-care.
REQ-018 Latency: a transfer in cycle N SHALL appear on wb_* no earlier than cycle N+2; with no contention it SHALL be exactly N+2.
REQ-019 On the same edge a granted hold SHALL either clear or reload from a simultaneous new transfer, giving a sustained throughput of 1 per requester per cycle.
REQ-020 rr_ptr SHALL update to (index of the last granted entry + 1) mod NUM_REQ when at least one grant is issued; otherwise it SHALL hold.
REQ-021 Starvation bound: a held entry SHALL be granted within ceil(NUM_REQ/NUM_PORTS) cycles of becoming valid.
REQ-022 Entries with uses_rd=0 SHALL still be arbitrated and output, because the active list needs completion.
REQ-023 flush SHALL clear all hold_valid bits and all wb_valid bits on the next edge and SHALL drop any transfer attempted in the flush cycle; rr_ptr SHALL be unaffected.
REQ-024 Port outputs SHALL never carry the same requester twice in one cycle.

Reset
REQ-025 On rst: hold_valid=0, wb_valid=0, rr_ptr=0, wb payload=0; req_ready=all-ones in the first cycle after reset.
REQ-026 rst SHALL take priority over flush and over any simultaneous transfer.

Structure
REQ-027 riscv_pkg SHALL hold the wb_req_t struct (al_idx, data, rd, uses_rd) and the defaults WB_NUM_REQ and WB_NUM_PORTS.
REQ-028 Round-robin multi-grant selection SHALL be a purely combinational sub-module, wb_rr_picker (inputs: valid vector and rr_ptr; outputs: per-port one-hot grant and next pointer).
REQ-029 Registered state SHALL be limited to the hold registers, rr_ptr and the wb_* output registers.

Verification
REQ-030 Single request: req0 valid with al_idx=5, data=0xDEADBEEF, rd=12 in cycle 1 -> port0 wb_valid=1 with the same fields in cycle 3; port1 wb_valid=0.
REQ-031 All 4 requesters valid in cycle 1, rr_ptr=0 -> cycle 3 ports carry req0/req1, cycle 4 carry req2/req3; req_ready[2:3]=0 in cycle 2.
REQ-032 Continuous requests on all 4 for 20 cycles -> every requester gets 10 grants (plus or minus 1); no entry waits more than 2 cycles; the same requester never appears twice in one cycle.
REQ-033 flush in cycle 2 after a 4-way request in cycle 1 -> no wb_valid in cycles 3-4; req_ready=all-ones in cycle 3.
REQ-034 rst asserted mid-stream together with flush and req_valid -> wb_valid=0 and rr_ptr=0 next cycle; the transfer is dropped.
REQ-035 req3 with uses_rd=0, al_idx=63 -> port0 wb_valid=1, wb_uses_rd=0, wb_al_idx=63 two cycles later.
